mux_scan_sequencer: RTL

//  Drives the 2-bit select of the 4:1 bit multiplexer and samples its output z.

---
 rtl/mux_scan_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
//
// Purpose:
//   Walks the 2-bit select of an external 4:1 bit multiplexer through
//   channels 0..3, holds each channel for DWELL cycles so the mux output can
//   settle, samples z_i at the end of each dwell window and assembles the four
//   samples into a 4-bit word. The word is offered downstream on a
//   valid/ready handshake. A scan is launched by start_i from IDLE, either as
//   a single shot or as a continuous loop (cont_i captured with start_i).
//
// Parameters:
//   DWELL  cycles the select is held per channel before sampling (>= 1)
//   CNT_W  dwell counter width, 2**CNT_W must be >= DWELL
//
// Ports:
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset
//   start_i      in   1  launch a scan (only honoured in IDLE)
//   cont_i       in   1  1 = rescan after every handshake, captured with start_i
//   abort_i      in   1  synchronous abort back to IDLE, highest priority
//   z_i          in   1  multiplexer output being scanned
//   sel_o        out  2  multiplexer select (current channel)
//   data_o       out  4  captured word, bit k = z_i sampled while sel_o == k
//   valid_o      out  1  data_o valid, held until accepted
//   ready_i      in   1  downstream accepts when valid_o && ready_i
//   busy_o       out  1  high whenever the sequencer is not IDLE
//   start_err_o  out  1  one-cycle pulse after start_i was seen while busy
// ---------------------------------------------------------------------------
module mux_scan_sequencer #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       cont_i,
  input  logic       abort_i,
  input  logic       z_i,
  output logic [1:0] sel_o,
  output logic [3:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       start_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sel;
  logic [2:0]       shadow;
  logic [3:0]       data;
  logic             valid;
  logic             cont_latch;
  logic             start_err;

  // Decoded control terms shared by the next-state logic and the datapath.
  logic dwell_done;
  logic last_channel;
  logic handshake;

  // The dwell window for the current channel closes when the counter reaches
  // DWELL-1; the sample is taken on that edge. The handshake term only means
  // something while a word is being offered.
  always_comb begin
    dwell_done   = (cnt == DWELL_LAST);
    last_channel = (sel == 2'd3);
    handshake    = valid && ready_i;
  end

  // State register. Everything returns to IDLE the moment reset is asserted,
  // so a scan interrupted by reset never produces a partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Abort overrides everything else, including a start in
  // IDLE and a handshake in HOLD. From HOLD the machine either loops back into
  // SCAN (continuous mode) or returns to IDLE once the word is accepted.
  always_comb begin
    state_next = state;
    if (abort_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state_next = SCAN;
          end
        end
        SCAN: begin
          if (dwell_done && last_channel) begin
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            state_next = cont_latch ? SCAN : IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Output decode from state. busy is purely a function of the current state
  // so downstream logic sees it in the same cycle the state changes.
  always_comb begin
    busy_o = (state != IDLE);
  end

  // Scan datapath: dwell counter, channel select, shadow bits for channels
  // 0..2 and the presented word. Channel 3 is not shadowed; its sample goes
  // straight into the output word together with the three shadowed bits.
  // Abort clears the scan position and drops any offered word but leaves
  // the last captured word on data_o, which only reset clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sel        <= 2'd0;
      shadow     <= 3'b000;
      data       <= 4'b0000;
      valid      <= 1'b0;
      cont_latch <= 1'b0;
    end else if (abort_i) begin
      cnt        <= '0;
      sel        <= 2'd0;
      valid      <= 1'b0;
      cont_latch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            cnt        <= '0;
            sel        <= 2'd0;
            cont_latch <= cont_i;
          end
        end
        SCAN: begin
          if (dwell_done) begin
            cnt <= '0;
            if (!last_channel) begin
              shadow[sel] <= z_i;
              sel         <= sel + 2'd1;
            end else begin
              data  <= {z_i, shadow};
              valid <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (handshake) begin
            valid <= 1'b0;
            sel   <= 2'd0;
            cnt   <= '0;
          end
        end
        default: begin
          cnt   <= '0;
          sel   <= 2'd0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  // A start request that arrives while the sequencer is busy is ignored and
  // flagged for exactly one cycle. An abort in the same cycle takes priority
  // and suppresses the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_err <= 1'b0;
    end else begin
      start_err <= start_i && (state != IDLE) && !abort_i;
    end
  end

  assign sel_o       = sel;
  assign data_o      = data;
  assign valid_o     = valid;
  assign start_err_o = start_err;

endmodule
